// File: rtl/dma_mem_responder.sv
// Memory-side responder for one DMA channel: serves src_read/dst_write handshakes
// from an internal single-port SRAM with range/alignment checks and fixed latency.
`timescale 1ns/1ps

module dma_mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] src_read_addr,
    input  logic                  src_read_valid,
    output logic                  src_read_ready,
    output logic [DATA_WIDTH-1:0] src_read_data,
    output logic                  src_read_error,
    input  logic [ADDR_WIDTH-1:0] dst_write_addr,
    input  logic [DATA_WIDTH-1:0] dst_write_data,
    input  logic                  dst_write_valid,
    output logic                  dst_write_ready,
    output logic                  dst_write_error,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    localparam int BYTE_LANES  = DATA_WIDTH / 8;
    localparam int OFFSET_BITS = $clog2(BYTE_LANES);
    localparam int INDEX_BITS  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTE_LANES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [3:0]            cnt_q;
    logic                  is_write_q;
    logic                  err_q;
    logic                  last_grant_q;
    logic [INDEX_BITS-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [7:0]            err_cnt_q;

    logic                  grant;
    logic                  grant_write;
    logic                  mem_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_offset;
    logic [ADDR_WIDTH-1:0] req_index;
    logic                  req_error;

    // last_grant_q = 1 means the previous grant went to the write side
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_read_valid || dst_write_valid) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                    if (src_read_valid && dst_write_valid) begin
                        grant_write = ~last_grant_q;
                    end else begin
                        grant_write = dst_write_valid;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_addr   = grant_write ? dst_write_addr : src_read_addr;
        req_offset = req_addr - BASE_ADDR;
        req_index  = req_offset >> OFFSET_BITS;
        req_error  = (req_addr < BASE_ADDR) ||
                     (req_index >= DEPTH_LIMIT) ||
                     ((req_addr & ALIGN_MASK) != '0);
    end

    assign mem_op = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            is_write_q   <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                cnt_q        <= WAIT_INIT;
                is_write_q   <= grant_write;
                last_grant_q <= grant_write;
                err_q        <= req_error;
                idx_q        <= req_index[INDEX_BITS-1:0];
                wdata_q      <= dst_write_data;
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (mem_op && err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // SRAM array is deliberately left unreset; state_q gates every access
    always_ff @(posedge clk) begin
        if (mem_op && is_write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
        if (mem_op && !is_write_q) begin
            rdata_q <= mem[idx_q];
        end
    end

    always_comb begin
        src_read_ready  = (state_q == RESP) && !is_write_q;
        dst_write_ready = (state_q == RESP) && is_write_q;
        src_read_error  = src_read_ready && err_q;
        dst_write_error = dst_write_ready && err_q;
        src_read_data   = (src_read_ready && !err_q) ? rdata_q : '0;
        busy            = (state_q != IDLE);
        err_cnt         = err_cnt_q;
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: three instances cover WAIT_STATES of 0, 3 and 2.
`timescale 1ns/1ps

module tb_dma_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] s0_addr, d0_addr, s2_addr, d2_addr, s3_addr, d3_addr;
    logic [63:0] s0_data, d0_data, s2_data, d2_data, s3_data, d3_data;
    logic        s0_valid, d0_valid, s2_valid, d2_valid, s3_valid, d3_valid;
    logic        s0_ready, d0_ready, s2_ready, d2_ready, s3_ready, d3_ready;
    logic        s0_err, d0_err, s2_err, d2_err, s3_err, d3_err;
    logic        busy0, busy2, busy3;
    logic [7:0]  err_cnt0, err_cnt2, err_cnt3;

    dma_mem_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .src_read_addr(s0_addr), .src_read_valid(s0_valid), .src_read_ready(s0_ready),
        .src_read_data(s0_data), .src_read_error(s0_err),
        .dst_write_addr(d0_addr), .dst_write_data(d0_data), .dst_write_valid(d0_valid),
        .dst_write_ready(d0_ready), .dst_write_error(d0_err),
        .busy(busy0), .err_cnt(err_cnt0)
    );

    dma_mem_responder #(.WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n),
        .src_read_addr(s2_addr), .src_read_valid(s2_valid), .src_read_ready(s2_ready),
        .src_read_data(s2_data), .src_read_error(s2_err),
        .dst_write_addr(d2_addr), .dst_write_data(d2_data), .dst_write_valid(d2_valid),
        .dst_write_ready(d2_ready), .dst_write_error(d2_err),
        .busy(busy2), .err_cnt(err_cnt2)
    );

    dma_mem_responder #(.WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .src_read_addr(s3_addr), .src_read_valid(s3_valid), .src_read_ready(s3_ready),
        .src_read_data(s3_data), .src_read_error(s3_err),
        .dst_write_addr(d3_addr), .dst_write_data(d3_data), .dst_write_valid(d3_valid),
        .dst_write_ready(d3_ready), .dst_write_error(d3_err),
        .busy(busy3), .err_cnt(err_cnt3)
    );

    // Drivers: entered just after a rising edge (cycle 0), return just after the edge following ready
    task automatic read0(input logic [31:0] addr, output int lat, output int rdy_cyc,
                         output logic [63:0] data, output logic err);
        lat = -1; rdy_cyc = -1; data = '0; err = 1'b0;
        s0_addr = addr; s0_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (s0_ready) begin lat = c; rdy_cyc = cyc; data = s0_data; err = s0_err; end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        s0_valid = 1'b0;
    endtask

    task automatic write0(input logic [31:0] addr, input logic [63:0] wdata,
                          output int lat, output logic err);
        lat = -1; err = 1'b0;
        d0_addr = addr; d0_data = wdata; d0_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (d0_ready) begin lat = c; err = d0_err; end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        d0_valid = 1'b0;
    endtask

    task automatic read2(input logic [31:0] addr, output int lat, output logic [63:0] data);
        lat = -1; data = '0;
        s2_addr = addr; s2_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (s2_ready) begin lat = c; data = s2_data; end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        s2_valid = 1'b0;
    endtask

    task automatic write2(input logic [31:0] addr, input logic [63:0] wdata, output int lat);
        lat = -1;
        d2_addr = addr; d2_data = wdata; d2_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (d2_ready) lat = c;
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        d2_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        s0_addr = '0; s0_valid = 0; d0_addr = '0; d0_data = '0; d0_valid = 0;
        s2_addr = '0; s2_valid = 0; d2_addr = '0; d2_data = '0; d2_valid = 0;
        s3_addr = '0; s3_valid = 0; d3_addr = '0; d3_data = '0; d3_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s0_ready, d0_ready, s0_err, d0_err, busy0} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {s0_ready, d0_ready, s0_err, d0_err, busy0});
        end
        checks++;
        if (s0_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", s0_data); end
        checks++;
        if (err_cnt0 !== 8'h0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt0); end
        @(posedge clk); #1;
        rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat, rc; logic err; logic [63:0] data;
        write0(32'h40, 64'h1122334455667788, lat, err);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected 2", lat); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL wr_error: got %b expected 0", err); end
        read0(32'h40, lat, rc, data, err);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected 2", lat); end
        checks++;
        if (data !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL rd_data: got %h expected 1122334455667788", data); end
    endtask

    task automatic test_wait_states();
        int rdy = -1;
        logic exp_busy;
        s3_addr = 32'h08; s3_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_busy = (c >= 1 && c <= 5);
            checks++;
            if (busy3 !== exp_busy) begin errors++; $display("[TB] FAIL ws_busy_c%0d: got %b expected %b", c, busy3, exp_busy); end
            if (s3_ready && rdy < 0) rdy = c;
            @(posedge clk); #1;
            if (rdy == c) s3_valid = 1'b0;
        end
        s3_valid = 1'b0;
        checks++;
        if (rdy !== 5) begin errors++; $display("[TB] FAIL ws_latency: got %0d expected 5", rdy); end
    endtask

    task automatic test_arbitration();
        int rd1 = -1, rd2 = -1, wr = -1, lat, rc;
        logic [63:0] rd2_data = '0, data;
        logic err;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        s0_addr = 32'h10; s0_valid = 1'b1;
        d0_addr = 32'h18; d0_data = 64'hA5; d0_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (s0_ready) begin
                if (rd1 < 0) rd1 = c;
                else if (rd2 < 0) begin rd2 = c; rd2_data = s0_data; end
            end
            if (d0_ready && wr < 0) wr = c;
            @(posedge clk); #1;
            if (rd1 == c) s0_addr = 32'h40;
            if (rd2 == c) s0_valid = 1'b0;
            if (wr == c) d0_valid = 1'b0;
        end
        s0_valid = 1'b0; d0_valid = 1'b0;
        checks++;
        if (rd1 !== 2) begin errors++; $display("[TB] FAIL arb_first_read: got %0d expected 2", rd1); end
        checks++;
        if (wr !== 5) begin errors++; $display("[TB] FAIL arb_pending_write: got %0d expected 5", wr); end
        checks++;
        if (rd2 !== 8) begin errors++; $display("[TB] FAIL arb_second_read: got %0d expected 8", rd2); end
        checks++;
        if (rd2_data !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL arb_read_data: got %h expected 1122334455667788", rd2_data); end
        read0(32'h18, lat, rc, data, err);
        checks++;
        if (data !== 64'hA5) begin errors++; $display("[TB] FAIL arb_write_commit: got %h expected a5", data); end
    endtask

    task automatic test_errors();
        int lat, rc; logic err; logic [63:0] data;
        write0(32'h44, 64'hDEADBEEFDEADBEEF, lat, err);
        checks++;
        if (err !== 1'b1 || lat !== 2) begin errors++; $display("[TB] FAIL misaligned_write: got err=%b lat=%0d expected err=1 lat=2", err, lat); end
        read0(32'h800, lat, rc, data, err);
        checks++;
        if (err !== 1'b1 || lat !== 2) begin errors++; $display("[TB] FAIL range_read: got err=%b lat=%0d expected err=1 lat=2", err, lat); end
        checks++;
        if (data !== 64'h0) begin errors++; $display("[TB] FAIL range_read_data: got %h expected 0", data); end
        read0(32'h40, lat, rc, data, err);
        checks++;
        if (data !== 64'h1122334455667788 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL mem_untouched: got %h err=%b expected 1122334455667788 err=0", data, err);
        end
        @(negedge clk);
        checks++;
        if (err_cnt0 !== 8'd2) begin errors++; $display("[TB] FAIL err_cnt_two: got %0d expected 2", err_cnt0); end
        @(posedge clk); #1;
        for (int i = 0; i < 298; i++) read0(32'h1000, lat, rc, data, err);
        @(negedge clk);
        checks++;
        if (err_cnt0 !== 8'd255) begin errors++; $display("[TB] FAIL err_cnt_saturate: got %0d expected 255", err_cnt0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [63:0] data;
        logic seen_ready = 1'b0;
        write2(32'h20, 64'h01, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("[TB] FAIL ws2_latency: got %0d expected 4", lat); end
        d2_addr = 32'h20; d2_data = 64'hFF; d2_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (d2_ready) seen_ready = 1'b1;
            @(posedge clk); #1;
        end
        rst2_n = 1'b0;
        d2_valid = 1'b0;
        @(negedge clk);
        if (d2_ready) seen_ready = 1'b1;
        checks++;
        if (busy2 !== 1'b0 || err_cnt2 !== 8'd0) begin
            errors++; $display("[TB] FAIL mid_reset_state: got busy=%b err_cnt=%0d expected busy=0 err_cnt=0", busy2, err_cnt2);
        end
        @(posedge clk); #1;
        rst2_n = 1'b1;
        @(negedge clk);
        if (d2_ready || s2_ready) seen_ready = 1'b1;
        checks++;
        if (seen_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", seen_ready); end
        @(posedge clk); #1;
        read2(32'h20, lat, data);
        checks++;
        if (data !== 64'h01 || lat !== 4) begin
            errors++; $display("[TB] FAIL mid_reset_memory: got %h lat=%0d expected 1 lat=4", data, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, cyc1, cyc2, wl; logic err1, err2, we; logic [63:0] data1, data2;
        write0(32'h000, 64'h0123456789ABCDEF, wl, we);
        write0(32'h7F8, 64'hFEDCBA9876543210, wl, we);
        read0(32'h000, lat1, cyc1, data1, err1);
        read0(32'h7F8, lat2, cyc2, data2, err2);
        checks++;
        if (data1 !== 64'h0123456789ABCDEF || err1 !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_first: got %h err=%b expected 0123456789abcdef err=0", data1, err1);
        end
        checks++;
        if (data2 !== 64'hFEDCBA9876543210 || err2 !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_last_word: got %h err=%b expected fedcba9876543210 err=0", data2, err2);
        end
        checks++;
        if (cyc2 - cyc1 !== 3) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 3", cyc2 - cyc1); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_arbitration();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
